// File: rtl/switch_pkg.sv
// switch_pkg: shared definitions for the 3x3 crossbar scheduler.
//   NUM_PORTS        number of inputs and outputs
//   port_idx_t       2-bit port index, 0 = none, 1..3 = port
//   DEST_*/LEN_*     header field positions (dest = [1:0], beat count L = [5:2])
//   out_state_t      per-output FSM state
package switch_pkg;

    localparam int NUM_PORTS = 3;

    typedef logic [1:0] port_idx_t;
    localparam port_idx_t PORT_NONE = 2'd0;

    localparam int DEST_LSB = 0;
    localparam int DEST_MSB = 1;
    localparam int LEN_LSB  = 2;
    localparam int LEN_MSB  = 5;
    localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;

    // Holds L+1, so one bit wider than the length field.
    localparam int BEATS_W  = LEN_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } out_state_t;

endpackage

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: combinational 3-way round-robin pick.
//   req    in  3  request vector, bit 0 = input 1
//   ptr    in  2  last winner (1..3); search starts at ptr+1 and wraps 3 -> 1
//   winner out 2  granted input index, 0 when nothing requests
module rr_arbiter3
    import switch_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  port_idx_t            ptr,
    output port_idx_t            winner
);

    always_comb begin
        winner = PORT_NONE;
        case (ptr)
            2'd1: begin
                if      (req[1]) winner = 2'd2;
                else if (req[2]) winner = 2'd3;
                else if (req[0]) winner = 2'd1;
            end
            2'd2: begin
                if      (req[2]) winner = 2'd3;
                else if (req[0]) winner = 2'd1;
                else if (req[1]) winner = 2'd2;
            end
            default: begin
                if      (req[0]) winner = 2'd1;
                else if (req[1]) winner = 2'd2;
                else if (req[2]) winner = 2'd3;
            end
        endcase
    end

endmodule

// File: rtl/rr_xbar_scheduler.sv
// rr_xbar_scheduler: 3x3 packet crossbar scheduler over show-ahead input FIFOs.
// Each output runs an IDLE/XFER FSM with its own round-robin pointer; a granted
// input is locked until its packet (header + L payload beats) has been popped.
//   clk, reset          clock, asynchronous active-high reset
//   data1..3, empty1..3 FIFO head words and empty flags
//   rdreq1..3           FIFO pops (combinational from state and empty)
//   sel1..3             input feeding each output (0 = none), registered
//   en1..3              output write strobes
//   busy1..3            output owned by a packet
//   pkt_cnt1..3         saturating completed-packet counters, present only
//                       when SCHED_STATS_EN is defined
module rr_xbar_scheduler
    import switch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    input  logic [7:0] data3,
    input  logic       empty1,
    input  logic       empty2,
    input  logic       empty3,
    output logic       rdreq1,
    output logic       rdreq2,
    output logic       rdreq3,
    output logic [1:0] sel1,
    output logic [1:0] sel2,
    output logic [1:0] sel3,
    output logic       en1,
    output logic       en2,
    output logic       en3,
    output logic       busy1,
    output logic       busy2,
    output logic       busy3
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0] pkt_cnt1,
    output logic [15:0] pkt_cnt2,
    output logic [15:0] pkt_cnt3
`endif
);

    logic [7:0]           data_a  [NUM_PORTS];
    logic [NUM_PORTS-1:0] empty_v;
    logic [1:0]           unused_hdr_bits;

    out_state_t           state_q [NUM_PORTS];
    port_idx_t            sel_q   [NUM_PORTS];
    port_idx_t            ptr_q   [NUM_PORTS];
    logic [BEATS_W-1:0]   beats_q [NUM_PORTS];

    logic [NUM_PORTS-1:0] locked;
    logic [NUM_PORTS-1:0] req     [NUM_PORTS];
    port_idx_t            winner  [NUM_PORTS];
    logic [LEN_W-1:0]     win_len [NUM_PORTS];
    logic [NUM_PORTS-1:0] en_v;
    logic [NUM_PORTS-1:0] rdreq_v;
    logic [NUM_PORTS-1:0] done_v;

    assign data_a[0] = data1;
    assign data_a[1] = data2;
    assign data_a[2] = data3;
    assign empty_v   = {empty3, empty2, empty1};
    assign unused_hdr_bits = {^{data1[7:6], data2[7:6]}, ^data3[7:6]};

    // An input is locked while any output is transferring from it, so its
    // payload words are never decoded as headers.
    always_comb begin
        locked = '0;
        for (int n = 0; n < NUM_PORTS; n++) begin
            for (int m = 0; m < NUM_PORTS; m++) begin
                if (state_q[m] == ST_XFER && sel_q[m] == port_idx_t'(n + 1))
                    locked[n] = 1'b1;
            end
        end
    end

    // Request matrix; destination 0 matches no output and so is never granted.
    always_comb begin
        for (int m = 0; m < NUM_PORTS; m++) begin
            req[m] = '0;
            for (int n = 0; n < NUM_PORTS; n++) begin
                req[m][n] = !empty_v[n] && !locked[n] &&
                            (data_a[n][DEST_MSB:DEST_LSB] == port_idx_t'(m + 1));
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_arb
            rr_arbiter3 u_arb (
                .req    (req[g]),
                .ptr    (ptr_q[g]),
                .winner (winner[g])
            );
        end
    endgenerate

    // Length field of each output's winner, and the strobe/pop fan-out.
    always_comb begin
        en_v    = '0;
        rdreq_v = '0;
        for (int m = 0; m < NUM_PORTS; m++) begin
            win_len[m] = '0;
            for (int n = 0; n < NUM_PORTS; n++) begin
                if (winner[m] == port_idx_t'(n + 1))
                    win_len[m] = data_a[n][LEN_MSB:LEN_LSB];
                if (state_q[m] == ST_XFER && sel_q[m] == port_idx_t'(n + 1) && !empty_v[n]) begin
                    en_v[m]    = 1'b1;
                    rdreq_v[n] = 1'b1;
                end
            end
            done_v[m] = en_v[m] && (beats_q[m] == BEATS_W'(1));
        end
    end

    // Output FSMs: grant on the IDLE edge, count pops in XFER, release on the
    // last pop. The release edge leaves one idle cycle before the next grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int m = 0; m < NUM_PORTS; m++) begin
                state_q[m] <= ST_IDLE;
                sel_q[m]   <= PORT_NONE;
                ptr_q[m]   <= 2'd3;
                beats_q[m] <= '0;
            end
        end else begin
            for (int m = 0; m < NUM_PORTS; m++) begin
                case (state_q[m])
                    ST_IDLE: begin
                        if (winner[m] != PORT_NONE) begin
                            state_q[m] <= ST_XFER;
                            sel_q[m]   <= winner[m];
                            ptr_q[m]   <= winner[m];
                            beats_q[m] <= {1'b0, win_len[m]} + BEATS_W'(1);
                        end
                    end
                    ST_XFER: begin
                        if (done_v[m]) begin
                            state_q[m] <= ST_IDLE;
                            sel_q[m]   <= PORT_NONE;
                            beats_q[m] <= '0;
                        end else if (en_v[m]) begin
                            beats_q[m] <= beats_q[m] - BEATS_W'(1);
                        end
                    end
                    default: state_q[m] <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef SCHED_STATS_EN
    logic [15:0] pkt_cnt_q [NUM_PORTS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int m = 0; m < NUM_PORTS; m++) pkt_cnt_q[m] <= '0;
        end else begin
            for (int m = 0; m < NUM_PORTS; m++) begin
                if (done_v[m] && pkt_cnt_q[m] != 16'hFFFF)
                    pkt_cnt_q[m] <= pkt_cnt_q[m] + 16'd1;
            end
        end
    end

    assign pkt_cnt1 = pkt_cnt_q[0];
    assign pkt_cnt2 = pkt_cnt_q[1];
    assign pkt_cnt3 = pkt_cnt_q[2];
`endif

    assign {rdreq3, rdreq2, rdreq1} = rdreq_v;
    assign {en3, en2, en1}          = en_v;
    assign sel1  = sel_q[0];
    assign sel2  = sel_q[1];
    assign sel3  = sel_q[2];
    assign busy1 = (state_q[0] == ST_XFER);
    assign busy2 = (state_q[1] == ST_XFER);
    assign busy3 = (state_q[2] == ST_XFER);

endmodule
